// File: rtl/prince_round_ctrl_pkg.sv
// Shared definitions for the PRINCE round controller: round constants, FSM encoding, index mapping.
// Latency: n/a (package, constants and pure functions only).
// Backpressure: n/a.
package prince_pkg;

    // The 12 PRINCE round constants, RC[0] = 0.
    localparam logic [63:0] RC [0:11] = '{
        64'h0000000000000000,
        64'h13198a2e03707344,
        64'ha4093822299f31d0,
        64'h082efa98ec4e6c89,
        64'h452821e638d01377,
        64'hbe5466cf34e90c6c,
        64'h7ef84f78fd955cb1,
        64'h85840851f1ac43aa,
        64'hc882d32f25323c54,
        64'h64a51195e0e3610d,
        64'hd3b5a399ca0c2399,
        64'hc0ac29b7c97c50dd
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Reduced round counts drop constants from the middle of the table so the
    // first and last constants, and the alpha-reflection pairing, are preserved.
    // Decryption walks the same table in reverse order.
    function automatic logic [3:0] rc_idx(input logic [3:0] r, input int nrounds, input logic enc);
        logic [3:0] idx;
        if (int'(r) < nrounds / 2) begin
            idx = r;
        end else begin
            idx = 4'(int'(r) + 12 - nrounds);
        end
        return enc ? idx : (4'd11 - idx);
    endfunction

    // Legal configurations: even round count 2..12, S-box pipeline depth 1..8.
    function automatic bit params_ok(input int nrounds, input int sbox_lat);
        return (nrounds >= 2) && (nrounds <= 12) && ((nrounds % 2) == 0) &&
               (sbox_lat >= 1) && (sbox_lat <= 8);
    endfunction

endpackage

// File: rtl/prince_rc_rom.sv
// Round-constant lookup: 4-bit index to 64-bit PRINCE constant; indices above 11 read as zero.
// Latency: combinational, 0 cycles.
// Backpressure: none, pure lookup.
module prince_rc_rom
    import prince_pkg::*;
(
    input  logic [3:0]  idx_i,
    output logic [63:0] rc_o
);

    // Table scan keeps the lookup free of out-of-range array reads.
    always_comb begin
        rc_o = '0;
        for (int i = 0; i < 12; i++) begin
            if (idx_i == 4'(i)) begin
                rc_o = RC[i];
            end
        end
    end

endmodule

// File: rtl/prince_round_ctrl.sv
// Round sequencer for the masked PRINCE datapath: NROUNDS rounds of SBOX_LAT cycles, key^constant per round.
// Latency: accept at t, out_valid first at t+NROUNDS*SBOX_LAT+1; one operation in flight at a time.
// Backpressure: in_ready low outside IDLE; DONE holds out_valid until out_ready. Optional abort: PRINCE_CTRL_ABORT_EN.
module prince_round_ctrl
    import prince_pkg::*;
#(
    parameter int NROUNDS  = 12,
    parameter int SBOX_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        enc,
    input  logic [63:0] k1,
`ifdef PRINCE_CTRL_ABORT_EN
    input  logic        abort,
`endif
    output logic [63:0] rc,
    output logic [3:0]  round,
    output logic        inv,
    output logic        state_load,
    output logic        state_en,
    output logic        busy,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam int              STEP_W     = (SBOX_LAT > 1) ? $clog2(SBOX_LAT) : 1;
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(SBOX_LAT - 1);
    localparam logic [3:0]      ROUND_LAST = 4'(NROUNDS - 1);
    localparam logic [3:0]      ROUND_HALF = 4'(NROUNDS / 2);

    if (!params_ok(NROUNDS, SBOX_LAT)) begin : g_bad_params
        $error("prince_round_ctrl: NROUNDS must be even in 2..12 and SBOX_LAT in 1..8");
    end

    state_e            state_q, state_d;
    logic [3:0]        r_q, r_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [63:0]       k1_q, k1_d;
    logic              enc_q, enc_d;

    logic [3:0]        rom_idx;
    logic [63:0]       rom_rc;
    logic              abort_hit;

`ifdef PRINCE_CTRL_ABORT_EN
    assign abort_hit = abort & (state_q != ST_IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    assign rom_idx = rc_idx(r_q, NROUNDS, enc_q);

    prince_rc_rom u_rom (
        .idx_i (rom_idx),
        .rc_o  (rom_rc)
    );

    // State register; reset outranks every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            r_q     <= '0;
            step_q  <= '0;
            k1_q    <= '0;
            enc_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            step_q  <= step_d;
            k1_q    <= k1_d;
            enc_q   <= enc_d;
        end
    end

    // Next-state logic, handshake and datapath strobes.
    always_comb begin
        state_d    = state_q;
        r_d        = r_q;
        step_d     = step_q;
        k1_d       = k1_q;
        enc_d      = enc_q;
        in_ready   = (state_q == ST_IDLE);
        state_load = in_valid & (state_q == ST_IDLE);
        state_en   = 1'b0;
        out_valid  = 1'b0;
        busy       = (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = ST_RUN;
                    r_d     = '0;
                    step_d  = '0;
                    k1_d    = k1;
                    enc_d   = enc;
                end
            end
            ST_RUN: begin
                if (step_q == STEP_LAST) begin
                    state_en = 1'b1;
                    step_d   = '0;
                    if (r_q == ROUND_LAST) begin
                        state_d = ST_DONE;
                        r_d     = '0;
                    end else begin
                        r_d = r_q + 4'd1;
                    end
                end else begin
                    step_d = step_q + STEP_W'(1);
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort discards the operation and the key it was using.
        if (abort_hit) begin
            state_d   = ST_IDLE;
            r_d       = '0;
            step_d    = '0;
            k1_d      = '0;
            state_en  = 1'b0;
            out_valid = 1'b0;
        end
    end

    // Round decodes come from registered state only, so they hold for the whole round.
    always_comb begin
        rc    = '0;
        round = '0;
        inv   = 1'b0;
        if (state_q == ST_RUN) begin
            rc    = k1_q ^ rom_rc;
            round = r_q;
            inv   = (r_q >= ROUND_HALF);
        end
    end

endmodule
